// File: rtl/axioma_irq_ctrl.sv
// Prioritised interrupt controller: latches edge sources, arbitrates by fixed priority
// and hands one registered request/vector to the core with ack, clear and RETI tracking.
module axioma_irq_ctrl #(
    parameter int unsigned           NUM_SRC        = 25,
    parameter logic [NUM_SRC-1:0]    EDGE_MASK      = 25'h0000003,
    parameter int unsigned           HOLDOFF_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               global_ie_i,
    input  logic               irq_ack_i,
    input  logic               reti_done_i,
    output logic               irq_req_o,
    output logic [4:0]         irq_vector_o,
    output logic [NUM_SRC-1:0] irq_clr_o,
    output logic               irq_active_o,
    output logic [NUM_SRC-1:0] pending_o
);

    typedef enum logic [1:0] {StIdle, StReq, StService, StHoldoff} state_e;

    state_e               state_q;
    logic [NUM_SRC-1:0]   src_q;
    logic [NUM_SRC-1:0]   latch_q, latch_d;
    logic [NUM_SRC-1:0]   clr_q;
    logic                 req_q;
    logic [4:0]           vec_q;
    logic                 active_q;
    logic [3:0]           cnt_q;

    logic [NUM_SRC-1:0]   pending;
    logic [NUM_SRC-1:0]   vec_onehot;
    logic [4:0]           win_vec;
    logic                 arb_go;
    logic                 req_still;

    // A new rising edge beats a simultaneous clear so no event is lost.
    always_comb begin
        latch_d = (irq_src_i & ~src_q) | (latch_q & ~clr_q);
        pending = (EDGE_MASK & latch_q) | (~EDGE_MASK & irq_src_i);
    end

    always_comb begin
        win_vec = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_vec = 5'(i + 1);
            end
        end
    end

    always_comb begin
        vec_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            vec_onehot[i] = (vec_q == 5'(i + 1));
        end
        req_still = |(pending & vec_onehot);
        arb_go    = global_ie_i && (|pending);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            src_q    <= '0;
            latch_q  <= '0;
            clr_q    <= '0;
            req_q    <= 1'b0;
            vec_q    <= 5'd0;
            active_q <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            src_q   <= irq_src_i;
            latch_q <= latch_d;
            clr_q   <= '0;
            unique case (state_q)
                StIdle: begin
                    if (arb_go) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        vec_q   <= win_vec;
                    end
                end
                StReq: begin
                    if (irq_ack_i) begin
                        state_q  <= StService;
                        req_q    <= 1'b0;
                        vec_q    <= 5'd0;
                        clr_q    <= vec_onehot;
                        active_q <= 1'b1;
                    end else if (!global_ie_i || !req_still) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                        vec_q   <= 5'd0;
                    end else if (win_vec < vec_q) begin
                        vec_q <= win_vec;
                    end
                end
                StService: begin
                    if (reti_done_i) begin
                        active_q <= 1'b0;
                        // With no holdoff the request may be raised as active drops.
                        if (HOLDOFF_CYCLES == 0) begin
                            if (arb_go) begin
                                state_q <= StReq;
                                req_q   <= 1'b1;
                                vec_q   <= win_vec;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            state_q <= StHoldoff;
                            cnt_q   <= 4'(HOLDOFF_CYCLES - 1);
                        end
                    end
                end
                StHoldoff: begin
                    if (cnt_q == 4'd0) begin
                        if (arb_go) begin
                            state_q <= StReq;
                            req_q   <= 1'b1;
                            vec_q   <= win_vec;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign irq_req_o    = req_q;
    assign irq_vector_o = vec_q;
    assign irq_clr_o    = clr_q;
    assign irq_active_o = active_q;
    assign pending_o    = pending;

endmodule

// File: tb/tb_axioma_irq_ctrl.sv
// Scenario bench for axioma_irq_ctrl; a HOLDOFF_CYCLES=0 copy shares the stimulus.
module tb_axioma_irq_ctrl;

    localparam int NS = 25;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [NS-1:0] src   = '0;
    logic          gie   = 1'b0;
    logic          ack   = 1'b0;
    logic          reti  = 1'b0;

    logic          req, act, req0, act0;
    logic [4:0]    vec, vec0;
    logic [NS-1:0] clr, pend, clr0, pend0;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   e;
    logic          seen;

    axioma_irq_ctrl #(.NUM_SRC(NS), .EDGE_MASK(25'h3), .HOLDOFF_CYCLES(1)) u_dut (
        .clk_i(clk), .reset_i(reset), .irq_src_i(src), .global_ie_i(gie), .irq_ack_i(ack),
        .reti_done_i(reti), .irq_req_o(req), .irq_vector_o(vec), .irq_clr_o(clr),
        .irq_active_o(act), .pending_o(pend)
    );

    axioma_irq_ctrl #(.NUM_SRC(NS), .EDGE_MASK(25'h3), .HOLDOFF_CYCLES(0)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .irq_src_i(src), .global_ie_i(gie), .irq_ack_i(ack),
        .reti_done_i(reti), .irq_req_o(req0), .irq_vector_o(vec0), .irq_clr_o(clr0),
        .irq_active_o(act0), .pending_o(pend0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assumes both copies are in REQ; acks, drops the given sources, returns via RETI.
    task automatic close_service(input logic [NS-1:0] drop);
        ack = 1'b1;
        step();
        ack = 1'b0;
        src = src & ~drop;
        step();
        reti = 1'b1;
        step();
        reti = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        src = 25'h4;
        gie = 1'b1;
        step();
        step();
        n_checks++;
        if (req !== 1'b0 || vec !== 5'd0 || clr !== '0 || act !== 1'b0 || pend !== 25'h4) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b vec=%0d clr=%h act=%b pend=%h, expected 0/0/0/0/4",
                     req, vec, clr, act, pend);
        end
        src = '0;
        gie = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        src = 25'h4;
        gie = 1'b1;
        exp_q.push_back(32'd3);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL basic_req: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        ack = 1'b1;
        exp_q.push_back(32'h4);
        step();
        ack = 1'b0;
        src = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (clr !== e[NS-1:0] || act !== 1'b1 || req !== 1'b0 || vec !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_ack: got clr=%h act=%b req=%b vec=%0d, expected clr=%h act=1 req=0 vec=0",
                     clr, act, req, vec, e[NS-1:0]);
        end
        step();
        n_checks++;
        if (clr !== '0 || act !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_clr_one_cycle: got clr=%h act=%b, expected clr=0 act=1", clr, act);
        end
        reti = 1'b1;
        step();
        reti = 1'b0;
        n_checks++;
        if (act !== 1'b0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_reti: got act=%b req=%b, expected act=0 req=0", act, req);
        end
        repeat (3) step();
    endtask

    task automatic test_priority();
        src = 25'h120;
        exp_q.push_back(32'd6);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL prio_lowest: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        ack = 1'b1;
        exp_q.push_back(32'h20);
        step();
        ack = 1'b0;
        src = 25'h100;
        e = exp_q.pop_front();
        n_checks++;
        if (clr !== e[NS-1:0]) begin
            n_fail++;
            $display("FAIL prio_clr: got clr=%h, expected clr=%h", clr, e[NS-1:0]);
        end
        step();
        reti = 1'b1;
        step();
        reti = 1'b0;
        exp_q.push_back(32'd9);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL prio_next: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        close_service(25'h100);
    endtask

    task automatic test_global_ie();
        gie  = 1'b0;
        src  = 25'h8;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (req !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL gie_masked: got a request with global_ie=0, expected none");
        end
        gie = 1'b1;
        exp_q.push_back(32'd4);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL gie_enable: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        src = '0;
        step();
        n_checks++;
        if (req !== 1'b0 || vec !== 5'd0) begin
            n_fail++;
            $display("FAIL withdraw: got req=%b vec=%0d, expected req=0 vec=0", req, vec);
        end
        step();
    endtask

    task automatic test_edge();
        src = 25'h1;
        step();
        src = '0;
        n_checks++;
        if (pend[0] !== 1'b1 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_latch: got pend0=%b req=%b, expected pend0=1 req=0", pend[0], req);
        end
        exp_q.push_back(32'd1);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL edge_req: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        ack = 1'b1;
        src = 25'h1;
        exp_q.push_back(32'h1);
        step();
        ack = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (clr !== e[NS-1:0]) begin
            n_fail++;
            $display("FAIL edge_clr: got clr=%h, expected clr=%h", clr, e[NS-1:0]);
        end
        step();
        n_checks++;
        if (pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_latch_cleared: got pend0=%b, expected 0", pend[0]);
        end
        reti = 1'b1;
        step();
        reti = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            step();
            if (req !== 1'b0 || req0 !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_no_rerequest: got a request with level held high, expected none");
        end
        src = '0;
        step();
        src = 25'h1;
        step();
        src = '0;
        exp_q.push_back(32'd1);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL edge_rearm: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        ack = 1'b1;
        exp_q.push_back(32'h1);
        step();
        ack = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (clr !== e[NS-1:0]) begin
            n_fail++;
            $display("FAIL edge_clr2: got clr=%h, expected clr=%h", clr, e[NS-1:0]);
        end
        src = 25'h1;
        step();
        src = '0;
        n_checks++;
        if (pend[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_set_wins: got pend0=%b, expected 1", pend[0]);
        end
        reti = 1'b1;
        step();
        reti = 1'b0;
        step();
        close_service('0);
    endtask

    task automatic test_holdoff();
        src = 25'h4;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        src = 25'h10;
        repeat (3) step();
        n_checks++;
        if (req !== 1'b0 || req0 !== 1'b0 || act !== 1'b1) begin
            n_fail++;
            $display("FAIL service_no_nest: got req=%b req0=%b act=%b, expected 0/0/1", req, req0, act);
        end
        reti = 1'b1;
        step();
        reti = 1'b0;
        n_checks++;
        if (act !== 1'b0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL holdoff1_t1: got act=%b req=%b, expected act=0 req=0", act, req);
        end
        exp_q.push_back(32'd5);
        e = exp_q.pop_front();
        n_checks++;
        if (act0 !== 1'b0 || req0 !== 1'b1 || vec0 !== e[4:0]) begin
            n_fail++;
            $display("FAIL holdoff0_t1: got act=%b req=%b vec=%0d, expected act=0 req=1 vec=%0d",
                     act0, req0, vec0, e[4:0]);
        end
        exp_q.push_back(32'd5);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL holdoff1_t2: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        close_service(25'h10);
    endtask

    task automatic test_back_to_back();
        ack  = 1'b1;
        reti = 1'b1;
        step();
        ack  = 1'b0;
        reti = 1'b0;
        n_checks++;
        if (req !== 1'b0 || clr !== '0 || act !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_idle: got req=%b clr=%h act=%b, expected 0/0/0", req, clr, act);
        end
        src = 25'h100;
        step();
        reti = 1'b1;
        exp_q.push_back(32'd9);
        step();
        reti = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0] || act !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_reti: got req=%b vec=%0d act=%b, expected req=1 vec=%0d act=0",
                     req, vec, act, e[4:0]);
        end
        src = 25'h120;
        exp_q.push_back(32'd6);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL rearb: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        ack = 1'b1;
        src = 25'h100;
        exp_q.push_back(32'h20);
        step();
        ack = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (clr !== e[NS-1:0] || act !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_wins_withdraw: got clr=%h act=%b, expected clr=%h act=1",
                     clr, act, e[NS-1:0]);
        end
        reti = 1'b1;
        step();
        reti = 1'b0;
        step();
        ack = 1'b1;
        src = 25'h120;
        exp_q.push_back(32'h100);
        step();
        ack = 1'b0;
        src = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (clr !== e[NS-1:0] || clr0 !== e[NS-1:0]) begin
            n_fail++;
            $display("FAIL ack_freezes_vector: got clr=%h clr0=%h, expected clr=%h",
                     clr, clr0, e[NS-1:0]);
        end
        reti = 1'b1;
        step();
        reti = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        src = 25'h5;
        step();
        src = 25'h4;
        exp_q.push_back(32'd1);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL reset_pre: got req=%b vec=%0d, expected req=1 vec=%0d", req, vec, e[4:0]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (req !== 1'b0 || vec !== 5'd0 || act !== 1'b0 || clr !== '0 || pend !== 25'h4) begin
            n_fail++;
            $display("FAIL reset_async: got req=%b vec=%0d act=%b clr=%h pend=%h, expected 0/0/0/0/4",
                     req, vec, act, clr, pend);
        end
        step();
        step();
        n_checks++;
        if (req !== 1'b0 || clr !== '0) begin
            n_fail++;
            $display("FAIL reset_no_clr: got req=%b clr=%h, expected req=0 clr=0", req, clr);
        end
        reset = 1'b0;
        exp_q.push_back(32'd3);
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (req !== 1'b1 || vec !== e[4:0]) begin
            n_fail++;
            $display("FAIL reset_rerequest: got req=%b vec=%0d, expected req=1 vec=%0d",
                     req, vec, e[4:0]);
        end
        close_service(25'h4);
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_priority();
        test_global_ie();
        test_edge();
        test_holdoff();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axioma_irq_ctrl.md
Name: axioma_irq_ctrl

Overview:
- Prioritised interrupt controller between the peripheral interrupt flags (INT0/1, timers, USART, SPI, TWI, ADC) and the CPU core.
- Replaces the combinational OR-plus-priority-chain at the CPU top.
- Latches edge-type sources, arbitrates by fixed priority (lowest index wins), and presents one registered request plus vector to the core with a request/acknowledge handshake.
- Issues per-source clear pulses, tracks in-service state through RETI, and enforces a post-RETI holdoff so one instruction executes between interrupts.

Parameters:
- NUM_SRC, 25, number of interrupt sources; source i maps to vector i+1 (vector 0 is reset); valid range 1..31
- EDGE_MASK, 25'h0000003, bit i set = source i is rising-edge latched internally; clear = level flag owned by the peripheral
- HOLDOFF_CYCLES, 1, cycles after reti_done before a new request may be raised; valid range 0..15

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_src  in  NUM_SRC  raw interrupt lines/flags from peripherals
- global_ie  in  1  SREG I bit from core
- irq_ack  in  1  one-cycle pulse: core has taken the current vector
- reti_done  in  1  one-cycle pulse: core executed RETI
- irq_req  out  1  interrupt request to core (registered)
- irq_vector  out  5  vector number of the request, 1..NUM_SRC; 0 when irq_req=0
- irq_clr  out  NUM_SRC  one-hot, one-cycle clear pulse to the serviced source
- irq_active  out  1  high from ack until reti_done
- pending  out  NUM_SRC  effective pending vector (debug)

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; irq_req, irq_vector, irq_clr, irq_active, edge latches, edge-history registers and holdoff counter all 0. Reset asserted mid-handshake aborts it with no clear pulse.
- Edge sources: src_q = irq_src registered. A latch sets when irq_src[i] & ~src_q[i], and clears when irq_clr[i]=1. If set and clear coincide, set wins.
- pending[i] = EDGE_MASK[i] ? latch[i] : irq_src[i]. The value is combinational from registers and inputs.
- Winner = lowest set index of pending. win_vec = index+1, 5-bit.
- FSM states: IDLE, REQ, SERVICE, HOLDOFF.
- IDLE: if global_ie && |pending, go to REQ. irq_req=1 and irq_vector=win_vec are registered, so latency is 1 cycle from pending/global_ie to irq_req.
- REQ (irq_req=1):
  - irq_ack=1: next cycle irq_req=0, irq_vector=0, irq_clr=one-hot of the vector held during the ack cycle (exactly 1 cycle), irq_active=1, state=SERVICE.
  - Else if !global_ie or the requested source is no longer pending (withdrawal): irq_req=0 and irq_vector=0 next cycle, state=IDLE.
  - Else if a higher-priority source is pending: irq_vector updates to the new win_vec next cycle while irq_req stays 1 (re-arbitration). The vector is never changed in a cycle where irq_ack=1.
  - Ack and withdrawal in the same cycle: ack wins and the clear is still issued.
- SERVICE: requests are ignored (no nesting). On reti_done, irq_active=0 next cycle; if HOLDOFF_CYCLES=0 go to IDLE, otherwise go to HOLDOFF with counter=HOLDOFF_CYCLES-1.
- HOLDOFF: counter decrements each cycle; at 0 go to IDLE. Arbitration resumes in IDLE.
- Spurious pulses:
  - irq_ack outside REQ is ignored.
  - reti_done outside SERVICE is ignored.
  - global_ie changes have no effect in SERVICE or HOLDOFF.
- Unused vector bits: irq_vector is 0 whenever irq_req=0. irq_clr is 0 except in the single cycle after an ack.

Test Plan:
- Level source 2 high, global_ie=1 → irq_req=1, irq_vector=3 on the next edge. Pulse irq_ack → next cycle irq_clr=25'h4 for 1 cycle, irq_active=1, irq_req=0.
- irq_src=25'h120 (sources 5 and 8) → irq_vector=6. After ack/reti and holdoff, with source 5 dropped → irq_vector=9.
- Source 3 pending with global_ie=0 for 10 cycles → irq_req stays 0. Raise global_ie → irq_req=1, vector 4 one cycle later. Drop source 3 before ack → irq_req=0 next cycle.
- Edge source 0: 1-cycle pulse on irq_src[0] → pending[0] latches, vector 1. After ack, irq_src[0] held high → no re-request. A new rising edge coinciding with irq_clr[0] leaves the latch set.
- In SERVICE, source 4 pending → no request. reti_done at cycle T → irq_active=0 at T+1, irq_req=1 (vector 5) at T+2 with HOLDOFF_CYCLES=1; at T+1 with HOLDOFF_CYCLES=0.
- Assert reset while irq_req=1 → irq_req, irq_vector, irq_active and latches are 0 immediately with no irq_clr pulse. After release, a pending level source re-requests 1 cycle later.
